// File: rtl/mul_sequencer.sv
// mul_sequencer: front-end for a 4-bit shift-add multiplier.
// Takes operand pairs over a valid/ready stream and starts the multiplier with a one-cycle
// trigger. It then waits for a rising edge on the multiplier's done level and pushes the
// product into a 2-entry result FIFO that a valid/ready consumer drains. If done never
// rises, a watchdog pushes an error entry instead.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_x/in_y   operand pair stream (x = multiplicand, y = multiplier)
//   mul_trig/mul_x/mul_y      multiplier start pulse and operands (held through WAIT)
//   mul_done/mul_product      multiplier done level and product
//   out_valid/out_ready       result stream handshake (FIFO non-empty / consumer pop)
//   out_product/out_err       FIFO head: product (0 for error entry), timeout flag
//   busy                      an operation is being issued or awaited
module mul_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_x,
    input  logic [3:0] in_y,
    output logic       mul_trig,
    output logic [3:0] mul_x,
    output logic [3:0] mul_y,
    input  logic       mul_done,
    input  logic [7:0] mul_product,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_product,
    output logic       out_err,
    output logic       busy
);

    localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e     state_q, state_d;
    logic [3:0] x_q, x_d, y_q, y_d;
    logic       done_q;
    logic       done_rise;
    logic [7:0] wdog_q, wdog_d;

    logic [8:0] fifo_q [2];
    logic       rd_ptr_q, wr_ptr_q;
    logic [1:0] count_q, count_d;
    logic       push, pop;
    logic [8:0] push_data;

    // A done level left high from an earlier op is not an edge, so it cannot complete
    // the current one.
    assign done_rise = mul_done & ~done_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        wdog_d    = wdog_q;
        push      = 1'b0;
        push_data = '0;
        in_ready  = 1'b0;
        case (state_q)
            StIdle: begin
                // An accepted pair always has a FIFO slot waiting for its result.
                in_ready = (count_q != 2'd2);
                if (in_valid && in_ready) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (done_rise) begin
                    push      = 1'b1;
                    push_data = {1'b0, mul_product};
                    state_d   = StIdle;
                end else if (wdog_q == WdogLast) begin
                    push      = 1'b1;
                    push_data = {1'b1, 8'h00};
                    state_d   = StIdle;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out_valid   = (count_q != 2'd0);
    assign pop         = out_valid & out_ready;
    assign out_product = out_valid ? fifo_q[rd_ptr_q][7:0] : 8'h00;
    assign out_err     = out_valid & fifo_q[rd_ptr_q][8];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    assign mul_trig = (state_q == StIssue);
    assign busy     = (state_q != StIdle);
    assign mul_x    = x_q;
    assign mul_y    = y_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            done_q    <= 1'b0;
            wdog_q    <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            done_q   <= mul_done;
            wdog_q   <= wdog_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
            end
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer: the bench plays the multiplier and the consumer. Expected
// results are kept in a queue of {err, product} entries ordered as they complete.
module tb_mul_sequencer;

    localparam int unsigned TIMEOUT = 15;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_x;
    logic [3:0] in_y;
    logic       mul_trig;
    logic [3:0] mul_x;
    logic [3:0] mul_y;
    logic       mul_done;
    logic [7:0] mul_product;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_product;
    logic       out_err;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    logic [8:0] exp_q [$];

    mul_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .mul_trig   (mul_trig),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_done   (mul_done),
        .mul_product(mul_product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .out_err    (out_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, want completion");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Offer a pair; returns at the negedge after acceptance (ISSUE cycle).
    task automatic offer(input logic [3:0] x, input logic [3:0] y, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        while (!ok && n < 50) begin
            if (in_ready === 1'b1) ok = 1'b1;
            cyc();
            n++;
        end
        in_valid = 1'b0;
        in_x     = 4'($urandom);
        in_y     = 4'($urandom);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL accept: in_ready never 1 within 50 cycles, want acceptance");
        end
    endtask

    // Pop the head and compare it against the oldest expected entry.
    task automatic pop_check(input string name);
        logic [8:0] exp;
        vectors++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: model queue empty, out_valid=%b", name, out_valid);
        end else begin
            exp = exp_q.pop_front();
            if (out_valid !== 1'b1 || {out_err, out_product} !== exp) begin
                errors++;
                $display("FAIL %s: valid=%b err=%b prod=%h, want valid=1 err=%b prod=%h",
                         name, out_valid, out_err, out_product, exp[8], exp[7:0]);
            end
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
    endtask

    // Act as the multiplier from the ISSUE cycle until the result is captured.
    task automatic serve(input logic [3:0] x, input logic [3:0] y, input logic [7:0] prod,
                         input int lat, input bit stuck, input bit pop_at_cap);
        int n;
        bit bad_hold;
        bad_hold = 1'b0;
        vectors++;
        if (mul_trig !== 1'b1 || mul_x !== x || mul_y !== y) begin
            errors++;
            $display("FAIL issue: trig=%b x=%h y=%h, want trig=1 x=%h y=%h",
                     mul_trig, mul_x, mul_y, x, y);
        end
        mul_done = 1'b0;
        cyc();
        vectors++;
        if (mul_trig !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_entry: trig=%b in_ready=%b busy=%b, want 0 0 1",
                     mul_trig, in_ready, busy);
        end
        if (stuck) begin
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                if (mul_x !== x || mul_y !== y || mul_trig !== 1'b0) bad_hold = 1'b1;
                n++;
                cyc();
            end
            exp_q.push_back({1'b1, 8'h00});
            vectors++;
            if (n != int'(TIMEOUT)) begin
                errors++;
                $display("FAIL timeout_len: %0d WAIT cycles, want %0d", n, TIMEOUT);
            end
        end else begin
            for (int i = 0; i < lat; i++) begin
                if (mul_x !== x || mul_y !== y || mul_trig !== 1'b0 || busy !== 1'b1)
                    bad_hold = 1'b1;
                cyc();
            end
            if (pop_at_cap) begin
                vectors++;
                if (exp_q.size() == 0 || out_valid !== 1'b1 ||
                    {out_err, out_product} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL cap_pop_head: valid=%b err=%b prod=%h, want old head",
                             out_valid, out_err, out_product);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                out_ready = 1'b1;
            end
            mul_done    = 1'b1;
            mul_product = prod;
            exp_q.push_back({1'b0, prod});
            cyc();
            out_ready = 1'b0;
        end
        vectors++;
        if (bad_hold) begin
            errors++;
            $display("FAIL operand_hold: operands/trig/busy changed in WAIT, want x=%h y=%h",
                     x, y);
        end
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL capture: busy=%b out_valid=%b, want 0 1", busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        vectors++;
        if ({out_valid, out_err, out_product, busy, mul_trig, mul_x, mul_y, in_ready} !==
            {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: valid=%b err=%b prod=%h busy=%b trig=%b x=%h y=%h rdy=%b",
                     out_valid, out_err, out_product, busy, mul_trig, mul_x, mul_y, in_ready);
        end
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        bit ok;
        offer(4'hF, 4'hF, ok);
        if (ok) serve(4'hF, 4'hF, 8'hE1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_product !== 8'hE1 || out_err !== 1'b0) begin
                errors++;
                $display("FAIL single_hold: valid=%b prod=%h err=%b, want 1 e1 0",
                         out_valid, out_product, out_err);
            end
            cyc();
        end
        pop_check("single_pop");
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_empty: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        offer(4'd3, 4'd5, ok);
        if (ok) serve(4'd3, 4'd5, 8'h0F, 1, 1'b0, 1'b0);
        offer(4'd0, 4'd9, ok);
        if (ok) serve(4'd0, 4'd9, 8'h00, 4, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_x     = 4'd7;
        in_y     = 4'd2;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL full_stall: in_ready=%b busy=%b, want 0 0", in_ready, busy);
            end
            cyc();
        end
        pop_check("b2b_pop0");
        offer(4'd7, 4'd2, ok);
        if (ok) serve(4'd7, 4'd2, 8'h0E, 2, 1'b0, 1'b0);
        pop_check("b2b_pop1");
        pop_check("b2b_pop2");
    endtask

    task automatic test_timeout();
        bit ok;
        offer(4'd5, 4'd5, ok);
        if (ok) serve(4'd5, 4'd5, 8'h00, 0, 1'b1, 1'b0);
        pop_check("timeout_entry");
    endtask

    task automatic test_done_wins();
        bit ok;
        // done rises on the last watchdog cycle: the product must win over the error
        offer(4'd9, 4'd3, ok);
        if (ok) serve(4'd9, 4'd3, 8'h1B, int'(TIMEOUT) - 1, 1'b0, 1'b0);
        pop_check("done_wins");
    endtask

    task automatic test_stale_done();
        bit ok;
        bit bad;
        bad = 1'b0;
        mul_done    = 1'b1;
        mul_product = 8'h55;
        cyc();
        cyc();
        offer(4'd6, 4'd7, ok);
        vectors++;
        if (mul_trig !== 1'b1) begin
            errors++;
            $display("FAIL stale_trig: mul_trig=%b, want 1", mul_trig);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (out_valid !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        mul_done = 1'b0;
        cyc();
        if (out_valid !== 1'b0) bad = 1'b1;
        mul_done    = 1'b1;
        mul_product = 8'h2A;
        exp_q.push_back({1'b0, 8'h2A});
        cyc();
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL stale_capture: result appeared before real done rise, want none");
        end
        pop_check("stale_result");
    endtask

    task automatic test_async_reset();
        bit ok;
        offer(4'd4, 4'd4, ok);
        if (ok) serve(4'd4, 4'd4, 8'h10, 2, 1'b0, 1'b0);
        offer(4'd8, 4'd8, ok);
        mul_done = 1'b0;
        cyc();
        cyc();
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_err, out_product, busy, mul_trig, mul_x, mul_y, in_ready} !==
            {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: valid=%b err=%b prod=%h busy=%b trig=%b x=%h y=%h rdy=%b",
                     out_valid, out_err, out_product, busy, mul_trig, mul_x, mul_y, in_ready);
        end
        exp_q.delete();
        cyc();
        rst = 1'b1;
        cyc();
        offer(4'd2, 4'd6, ok);
        if (ok) serve(4'd2, 4'd6, 8'h0C, 1, 1'b0, 1'b0);
        pop_check("post_reset");
    endtask

    task automatic test_push_pop();
        bit ok;
        offer(4'd1, 4'd3, ok);
        if (ok) serve(4'd1, 4'd3, 8'h03, 0, 1'b0, 1'b0);
        offer(4'd5, 4'd6, ok);
        if (ok) serve(4'd5, 4'd6, 8'h1E, 2, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (exp_q.size() != 1 || out_valid !== 1'b1 ||
                {out_err, out_product} !== exp_q[0]) begin
                errors++;
                $display("FAIL push_pop_head: valid=%b err=%b prod=%h, want 1 0 1e",
                         out_valid, out_err, out_product);
            end
            cyc();
        end
        pop_check("push_pop_drain");
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_count: out_valid=%b after one pop, want 0", out_valid);
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] p;
        bit stuck;
        int lat;
        for (int i = 0; i < 24; i++) begin
            if (exp_q.size() == 2 || (exp_q.size() != 0 && $urandom_range(0, 1) == 1))
                pop_check("rand_pop");
            x     = 4'($urandom);
            y     = 4'($urandom);
            p     = {4'h0, x} * {4'h0, y};
            stuck = ($urandom_range(0, 7) == 0);
            lat   = int'($urandom_range(0, TIMEOUT - 1));
            offer(x, y, ok);
            if (ok) serve(x, y, p, lat, stuck, 1'b0);
        end
        while (exp_q.size() != 0) pop_check("rand_drain");
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_empty: out_valid=%b, want 0", out_valid);
        end
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_x        = '0;
        in_y        = '0;
        mul_done    = 1'b0;
        mul_product = '0;
        out_ready   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_done_wins();
        test_stale_done();
        test_async_reset();
        test_push_pop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
